// File: rtl/string_receiver.sv
// -----------------------------------------------------------------------------
// string_receiver
// Decodes a single-wire WS2812-style LED serial stream back into 24-bit pixel
// words, frame boundaries and error flags. Runs in the clk_20 domain; sdi is
// asynchronous and is synchronized internally.
//
// Ports:
//   clk           in   1   system clock (clk_20)
//   reset_n       in   1   synchronous reset, active-low
//   sdi           in   1   serial LED data, asynchronous
//   pixel_data    out  24  last decoded pixel, first received bit in bit 23
//   pixel_valid   out  1   one-cycle strobe: pixel_data updated
//   frame_done    out  1   one-cycle strobe: latch/reset gap detected
//   frame_pixels  out  16  pixels in completed frame, held until next frame_done
//   frame_err     out  1   frame ended with a partial pixel, held with frame_pixels
//   bit_err       out  1   one-cycle strobe: high pulse too short or too long
// -----------------------------------------------------------------------------
module string_receiver #(
    parameter int unsigned CLK_PERIOD_NS = 50,
    parameter int unsigned T1_MIN_NS     = 600,
    parameter int unsigned TH_MIN_NS     = 150,
    parameter int unsigned TH_MAX_NS     = 2000,
    parameter int unsigned T_RESET_NS    = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sdi,
    output logic [23:0] pixel_data,
    output logic        pixel_valid,
    output logic        frame_done,
    output logic [15:0] frame_pixels,
    output logic        frame_err,
    output logic        bit_err
);

    // Widths
    localparam int unsigned PIX_W = 24;
    localparam int unsigned SHR_W = PIX_W - 1;
    localparam int unsigned HC_W  = 8;
    localparam int unsigned LC_W  = 11;
    localparam int unsigned BC_W  = 5;
    localparam int unsigned PC_W  = 16;

    // Cycle thresholds derived from the ns timing parameters
    localparam int unsigned THRESH       = T1_MIN_NS / CLK_PERIOD_NS;
    localparam int unsigned MIN_HIGH     = TH_MIN_NS / CLK_PERIOD_NS;
    localparam int unsigned MAX_HIGH     = TH_MAX_NS / CLK_PERIOD_NS;
    localparam int unsigned RESET_CYCLES = T_RESET_NS / CLK_PERIOD_NS;

    localparam logic [HC_W-1:0] THRESH_C   = HC_W'(THRESH);
    localparam logic [HC_W-1:0] MIN_HIGH_C = HC_W'(MIN_HIGH);
    localparam logic [HC_W-1:0] MAX_HIGH_C = HC_W'(MAX_HIGH);
    localparam logic [LC_W-1:0] RESET_C    = LC_W'(RESET_CYCLES);
    localparam logic [BC_W-1:0] LAST_BIT   = BC_W'(PIX_W - 1);

    localparam logic [HC_W-1:0] HC_MAX = {HC_W{1'b1}};
    localparam logic [LC_W-1:0] LC_MAX = {LC_W{1'b1}};
    localparam logic [PC_W-1:0] PC_MAX = {PC_W{1'b1}};

    // FSM encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_LOW  = 2'd2;

    // Input path
    logic sdi_meta;
    logic sdi_s;
    logic sdi_d;
    logic rise;
    logic fall;

    // Decoder state
    logic [1:0]       state,        state_nxt;
    logic [HC_W-1:0]  high_cnt,     high_cnt_nxt;
    logic [LC_W-1:0]  low_cnt,      low_cnt_nxt;
    logic [BC_W-1:0]  bit_cnt,      bit_cnt_nxt;
    logic [PC_W-1:0]  pix_cnt,      pix_cnt_nxt;
    logic [SHR_W-1:0] shreg,        shreg_nxt;

    // Next values of the registered outputs
    logic [PIX_W-1:0] pixel_data_nxt;
    logic             pixel_valid_nxt;
    logic             frame_done_nxt;
    logic [PC_W-1:0]  frame_pixels_nxt;
    logic             frame_err_nxt;
    logic             bit_err_nxt;

    logic             bit_val_c;

    // Two-flop synchronizer plus edge-detect delay; all reset high so a line
    // already high at reset release never looks like a rising edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sdi_meta <= 1'b1;
            sdi_s    <= 1'b1;
            sdi_d    <= 1'b1;
        end else begin
            sdi_meta <= sdi;
            sdi_s    <= sdi_meta;
            sdi_d    <= sdi_s;
        end
    end

    assign rise = sdi_s & ~sdi_d;
    assign fall = ~sdi_s & sdi_d;

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            high_cnt     <= '0;
            low_cnt      <= '0;
            bit_cnt      <= '0;
            pix_cnt      <= '0;
            shreg        <= '0;
            pixel_data   <= '0;
            pixel_valid  <= 1'b0;
            frame_done   <= 1'b0;
            frame_pixels <= '0;
            frame_err    <= 1'b0;
            bit_err      <= 1'b0;
        end else begin
            state        <= state_nxt;
            high_cnt     <= high_cnt_nxt;
            low_cnt      <= low_cnt_nxt;
            bit_cnt      <= bit_cnt_nxt;
            pix_cnt      <= pix_cnt_nxt;
            shreg        <= shreg_nxt;
            pixel_data   <= pixel_data_nxt;
            pixel_valid  <= pixel_valid_nxt;
            frame_done   <= frame_done_nxt;
            frame_pixels <= frame_pixels_nxt;
            frame_err    <= frame_err_nxt;
            bit_err      <= bit_err_nxt;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_nxt        = state;
        high_cnt_nxt     = high_cnt;
        low_cnt_nxt      = low_cnt;
        bit_cnt_nxt      = bit_cnt;
        pix_cnt_nxt      = pix_cnt;
        shreg_nxt        = shreg;
        pixel_data_nxt   = pixel_data;
        pixel_valid_nxt  = 1'b0;
        frame_done_nxt   = 1'b0;
        frame_pixels_nxt = frame_pixels;
        frame_err_nxt    = frame_err;
        bit_err_nxt      = 1'b0;
        bit_val_c        = 1'b0;

        case (state)
            S_IDLE: begin
                if (rise) begin
                    state_nxt    = S_HIGH;
                    high_cnt_nxt = HC_W'(1);
                end
            end

            S_HIGH: begin
                if (fall) begin
                    // high_cnt holds the full pulse width here
                    state_nxt   = S_LOW;
                    low_cnt_nxt = LC_W'(1);
                    if ((high_cnt < MIN_HIGH_C) || (high_cnt > MAX_HIGH_C)) begin
                        bit_err_nxt = 1'b1;
                    end else begin
                        bit_val_c = (high_cnt >= THRESH_C);
                        shreg_nxt = {shreg[SHR_W-2:0], bit_val_c};
                        if (bit_cnt == LAST_BIT) begin
                            pixel_data_nxt  = {shreg, bit_val_c};
                            pixel_valid_nxt = 1'b1;
                            bit_cnt_nxt     = '0;
                            if (pix_cnt != PC_MAX) begin
                                pix_cnt_nxt = pix_cnt + PC_W'(1);
                            end
                        end else begin
                            bit_cnt_nxt = bit_cnt + BC_W'(1);
                        end
                    end
                end else if (high_cnt != HC_MAX) begin
                    high_cnt_nxt = high_cnt + HC_W'(1);
                end
            end

            S_LOW: begin
                if (low_cnt == RESET_C) begin
                    // Latch gap: close the frame, drop any partial pixel
                    frame_done_nxt   = 1'b1;
                    frame_pixels_nxt = pix_cnt;
                    frame_err_nxt    = (bit_cnt != '0);
                    bit_cnt_nxt      = '0;
                    pix_cnt_nxt      = '0;
                    state_nxt        = S_IDLE;
                end else if (low_cnt != LC_MAX) begin
                    low_cnt_nxt = low_cnt + LC_W'(1);
                end
                // A rise landing on the gap-completion cycle still starts a bit
                if (rise) begin
                    state_nxt    = S_HIGH;
                    high_cnt_nxt = HC_W'(1);
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_string_receiver.sv
// -----------------------------------------------------------------------------
// tb_string_receiver
// Scoreboard bench for string_receiver: stimulus pushes expected pixels,
// frames and bit errors into queues; a monitor pops and compares whenever the
// DUT strobes pixel_valid, frame_done or bit_err.
// -----------------------------------------------------------------------------
module tb_string_receiver;

    typedef struct packed {
        logic [15:0] pixels;
        logic        err;
    } frame_t;

    logic        clk;
    logic        reset_n;
    logic        sdi;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic        frame_done;
    logic [15:0] frame_pixels;
    logic        frame_err;
    logic        bit_err;

    int n_checks;
    int n_pass;
    int frames_pushed;
    int frames_seen;

    logic [23:0] pix_q[$];
    frame_t      frame_q[$];
    string       err_q[$];

    logic [23:0] exp_pix_m;
    frame_t      exp_frm_m;
    string       err_tag_m;

    string_receiver dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sdi         (sdi),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .frame_done  (frame_done),
        .frame_pixels(frame_pixels),
        .frame_err   (frame_err),
        .bit_err     (bit_err)
    );

    // 20 MHz clock
    initial clk = 1'b0;
    always #25 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // High for hi cycles, then low for lo cycles; inputs change on negedge
    task automatic pulse(input int hi, input int lo);
        sdi = 1'b1;
        repeat (hi) @(negedge clk);
        sdi = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    // Nominal bit timing, with an optional extra pulse after bit ins_idx and
    // an optional non-nominal low time after bit long_idx (-1 disables)
    task automatic send_pixel(input logic [23:0] w, input int ins_idx, input int ins_hi,
                              input int long_idx, input int long_lo);
        logic b;
        int   lo;
        for (int i = 0; i < 24; i++) begin
            b  = w[23-i];
            lo = (i == long_idx) ? long_lo : (b ? 9 : 17);
            pulse(b ? 16 : 8, lo);
            if (i == ins_idx) pulse(ins_hi, 10);
        end
    endtask

    task automatic exp_frame(input int n, input logic e);
        frame_t f;
        f.pixels = 16'(n);
        f.err    = e;
        frame_q.push_back(f);
        frames_pushed++;
    endtask

    task automatic gap();
        sdi = 1'b0;
        repeat (1200) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " pixel_data"},   32'(pixel_data),   32'h0);
        check({tag, " pixel_valid"},  32'(pixel_valid),  32'h0);
        check({tag, " frame_done"},   32'(frame_done),   32'h0);
        check({tag, " frame_pixels"}, 32'(frame_pixels), 32'h0);
        check({tag, " frame_err"},    32'(frame_err),    32'h0);
        check({tag, " bit_err"},      32'(bit_err),      32'h0);
    endtask

    // Monitor: compare every DUT strobe against the head of its queue
    always @(negedge clk) begin
        if (pixel_valid) begin
            if (pix_q.size() == 0) begin
                n_checks++;
                $display("FAIL pixel_valid unexpected: data 0x%06h, expected no strobe", pixel_data);
            end else begin
                exp_pix_m = pix_q.pop_front();
                check("pixel_data", 32'(pixel_data), 32'(exp_pix_m));
            end
        end
        if (frame_done) begin
            frames_seen++;
            if (frame_q.size() == 0) begin
                n_checks++;
                $display("FAIL frame_done unexpected: pixels %0d, expected no strobe", frame_pixels);
            end else begin
                exp_frm_m = frame_q.pop_front();
                check("frame_pixels", 32'(frame_pixels), 32'(exp_frm_m.pixels));
                check("frame_err",    32'(frame_err),    32'(exp_frm_m.err));
            end
        end
        if (bit_err) begin
            n_checks++;
            if (err_q.size() == 0) begin
                $display("FAIL bit_err unexpected: got 1, expected 0");
            end else begin
                err_tag_m = err_q.pop_front();
                n_pass++;
            end
        end
    end

    // Watchdog
    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: run exceeded 60000 cycles, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        frames_pushed = 0;
        frames_seen   = 0;
        reset_n       = 1'b0;
        sdi           = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        // Single pixel
        pix_q.push_back(24'hA5C3F0);
        exp_frame(1, 1'b0);
        send_pixel(24'hA5C3F0, -1, 0, -1, 0);
        gap();

        // Back-to-back pixels
        pix_q.push_back(24'h000000);
        pix_q.push_back(24'hFFFFFF);
        pix_q.push_back(24'h123456);
        exp_frame(3, 1'b0);
        send_pixel(24'h000000, -1, 0, -1, 0);
        send_pixel(24'hFFFFFF, -1, 0, -1, 0);
        send_pixel(24'h123456, -1, 0, -1, 0);
        gap();

        // Short glitch between bits 5 and 6
        err_q.push_back("glitch 2");
        pix_q.push_back(24'h5A5A5A);
        exp_frame(1, 1'b0);
        send_pixel(24'h5A5A5A, 5, 2, -1, 0);
        gap();

        // Over-long pulse between bits 5 and 6
        err_q.push_back("long 45");
        pix_q.push_back(24'h5A5A5A);
        exp_frame(1, 1'b0);
        send_pixel(24'h5A5A5A, 5, 45, -1, 0);
        gap();

        // Partial frame, then a clean one
        exp_frame(0, 1'b1);
        for (int i = 0; i < 10; i++) pulse(16, 9);
        gap();
        pix_q.push_back(24'h00FF00);
        exp_frame(1, 1'b0);
        send_pixel(24'h00FF00, -1, 0, -1, 0);
        gap();

        // Reset during the high phase of bit 12
        for (int i = 0; i < 11; i++) pulse(16, 9);
        sdi = 1'b1;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("mid-bit reset");
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        sdi = 1'b0;
        repeat (20) @(negedge clk);
        pix_q.push_back(24'hC0FFEE);
        exp_frame(1, 1'b0);
        send_pixel(24'hC0FFEE, -1, 0, -1, 0);
        gap();

        // High-width boundaries: 11 -> 0, 12 -> 1; 40 -> 1, 3 -> 0; 2 and 41 rejected
        pix_q.push_back(24'h555555);
        pix_q.push_back(24'hAAAAAA);
        err_q.push_back("high 2");
        err_q.push_back("high 41");
        exp_frame(2, 1'b0);
        for (int i = 0; i < 24; i++) pulse(((i % 2) == 1) ? 12 : 11, 14);
        for (int i = 0; i < 24; i++) begin
            pulse(((i % 2) == 1) ? 3 : 40, 20);
            if (i == 3) pulse(2, 20);
            if (i == 7) pulse(41, 20);
        end
        gap();

        // Low-width boundary: 999 low keeps the frame open
        pix_q.push_back(24'h0F0F0F);
        send_pixel(24'h0F0F0F, -1, 0, 11, 999);
        check("frames after 999-cycle low", 32'(frames_seen), 32'(frames_pushed));
        // 1000 low closes it, and the coincident rise starts the next pixel
        pix_q.push_back(24'h81C3E7);
        exp_frame(2, 1'b0);
        send_pixel(24'h81C3E7, -1, 0, 23, 1000);
        pix_q.push_back(24'h3C3C3C);
        exp_frame(1, 1'b0);
        send_pixel(24'h3C3C3C, -1, 0, -1, 0);
        gap();

        repeat (20) @(negedge clk);
        check("pixel queue drained", 32'(pix_q.size()),   32'h0);
        check("frame queue drained", 32'(frame_q.size()), 32'h0);
        check("bit_err queue drained", 32'(err_q.size()), 32'h0);
        check("frame count", 32'(frames_seen), 32'(frames_pushed));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
